wave_pwm_demod: RTL and testbench

//  Receive-side decoder for the wave-table PWM outputs (qcos/qsin/qcomplex).
//  It frame-syncs to one PWM stream on its rising edge and measures high time
//  per carrier period. Each period yields one D-bit duty sample, delivered over
//  a valid/ready handshake. Used for loopback self-test and for DAC-less capture.

---
 rtl/wave_pwm_demod_if.sv | 21 ++
 rtl/wave_pwm_demod.sv | 166 ++++++++++++++++
 tb/tb_wave_pwm_demod.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/wave_pwm_demod_if.sv
// Duty-sample handshake between the PWM demodulator and its consumer.
// The demodulator drives sample/sample_valid, the consumer drives sample_ready.
interface wave_pwm_demod_if #(
  parameter int Dbits = 16
);
  logic [Dbits-1:0] sample;
  logic             sample_valid;
  logic             sample_ready;

  modport master (
    output sample,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/wave_pwm_demod.sv
// Receive-side wave-table PWM decoder: syncs to the stream's rising edge and
// measures high time per carrier period, one D-bit duty sample per period.
module wave_pwm_demod #(
  parameter int Dbits = 16,
  parameter int Dover = 1,
  localparam int O    = $clog2(Dbits),
  localparam int W    = Dbits + Dover
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [O-1:0]     divSel,
  input  logic             pwm_in,
  wave_pwm_demod_if.master smp,
  output logic             overrun,
  output logic             lock_err,
  output logic             locked
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEEK    = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [W-1:0]     phase_reg, phase_next;
  logic [W-1:0]     duty_reg, duty_next;
  logic [1:0]       good_reg, good_next;
  logic             locked_reg, locked_next;
  logic             lock_err_reg, lock_err_next;
  logic             overrun_reg, overrun_next;
  logic [Dbits-1:0] sample_reg, sample_next;
  logic             valid_reg, valid_next;
  logic [O-1:0]     div_reg;
  // [0] first synchroniser flop, [1] in_s, [2] in_s delayed for edge detect
  logic [2:0]       sync_reg;

  logic             in_s;
  logic             rise;
  logic [W-1:0]     step;
  logic [W-1:0]     contrib;
  logic [W:0]       sum;
  logic [W:0]       total;
  logic [W-1:0]     total_sat;
  logic [Dbits-1:0] frame_sample;
  logic             frame_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      phase_reg    <= '0;
      duty_reg     <= '0;
      good_reg     <= '0;
      locked_reg   <= 1'b0;
      lock_err_reg <= 1'b0;
      overrun_reg  <= 1'b0;
      sample_reg   <= '0;
      valid_reg    <= 1'b0;
      div_reg      <= '0;
      sync_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      duty_reg     <= duty_next;
      good_reg     <= good_next;
      locked_reg   <= locked_next;
      lock_err_reg <= lock_err_next;
      overrun_reg  <= overrun_next;
      sample_reg   <= sample_next;
      valid_reg    <= valid_next;
      div_reg      <= divSel;
      sync_reg     <= {sync_reg[1:0], pwm_in};
    end
  end

  always_comb begin
    in_s          = sync_reg[1];
    rise          = sync_reg[1] & ~sync_reg[2];
    step          = W'(1) << divSel;
    contrib       = in_s ? step : '0;
    sum           = {1'b0, phase_reg} + {1'b0, step};
    total         = {1'b0, duty_reg} + {1'b0, contrib};
    // A full-high period overflows by exactly one LSB; clamp to full scale.
    total_sat     = total[W] ? '1 : total[W-1:0];
    frame_sample  = Dbits'(total_sat >> Dover);

    state_next    = state_reg;
    phase_next    = phase_reg;
    duty_next     = duty_reg;
    good_next     = good_reg;
    locked_next   = locked_reg;
    lock_err_next = 1'b0;
    overrun_next  = 1'b0;
    sample_next   = sample_reg;
    valid_next    = valid_reg;
    frame_end     = 1'b0;

    if (!enable) begin
      state_next  = IDLE;
      phase_next  = '0;
      duty_next   = '0;
      good_next   = '0;
      locked_next = 1'b0;
    end else if (state_reg != IDLE && divSel != div_reg) begin
      // New period length: the partial frame is meaningless, hunt for an edge.
      state_next  = SEEK;
      phase_next  = '0;
      duty_next   = '0;
      good_next   = '0;
      locked_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = SEEK;
        end
        SEEK: begin
          if (rise) begin
            state_next = MEASURE;
            phase_next = step;
            duty_next  = step;
          end
        end
        MEASURE: begin
          if (rise && phase_reg != '0) begin
            phase_next    = step;
            duty_next     = step;
            lock_err_next = 1'b1;
            good_next     = '0;
            locked_next   = 1'b0;
          end else if (sum[W]) begin
            frame_end   = 1'b1;
            phase_next  = '0;
            duty_next   = '0;
            good_next   = (good_reg == 2'd2) ? 2'd2 : good_reg + 2'd1;
            locked_next = (good_next == 2'd2);
          end else begin
            phase_next = sum[W-1:0];
            duty_next  = duty_reg + contrib;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end

    if (frame_end) begin
      if (!valid_reg || smp.sample_ready) begin
        sample_next = frame_sample;
        valid_next  = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end else if (valid_reg && smp.sample_ready) begin
      valid_next = 1'b0;
    end
  end

  assign smp.sample       = sample_reg;
  assign smp.sample_valid = valid_reg;
  assign overrun          = overrun_reg;
  assign lock_err         = lock_err_reg;
  assign locked           = locked_reg;

endmodule

// File: tb/tb_wave_pwm_demod.sv
// Bench for wave_pwm_demod (Dbits=8, Dover=1): scripted scenarios plus random
// segments, checked every cycle against a cycle/high-count frame model.
module tb_wave_pwm_demod;
  localparam int D = 8;
  localparam int F = 1;
  localparam int W = D + F;
  localparam int O = $clog2(D);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic [O-1:0] div_sel = '0;
  logic         pwm_in = 1'b0;
  logic         overrun, lock_err, locked;

  wave_pwm_demod_if #(.Dbits(D)) smp_if();

  wave_pwm_demod #(.Dbits(D), .Dover(F)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .divSel   (div_sel),
    .pwm_in   (pwm_in),
    .smp      (smp_if),
    .overrun  (overrun),
    .lock_err (lock_err),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // stimulus generator
  int gen_per = 512, gen_hi = 128, gen_cnt = 0, force_lvl = -1, ready_mode = 0;

  // frame model: mode 0 idle, 1 seek, 2 measure; n = cycles in frame, hi = high cycles
  int       m_mode = 0, m_n = 0, m_hi = 0, m_good = 0, m_prev_div = 0;
  bit       m_p1 = 0, m_p2 = 0, m_p3 = 0;
  int       e_sample = 0;
  bit       e_valid = 0, e_ovr = 0, e_lerr = 0, e_locked = 0;

  int       n_lerr = 0, n_ovr = 0, n_acc = 0;
  int       last_acc = 0;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit ins, rise;
    int step, per, val;
    ins  = m_p2;
    rise = m_p2 & ~m_p3;
    if (rst) begin
      m_mode = 0; m_n = 0; m_hi = 0; m_good = 0; m_prev_div = 0;
      m_p1 = 0; m_p2 = 0; m_p3 = 0;
      e_sample = 0; e_valid = 0; e_ovr = 0; e_lerr = 0; e_locked = 0;
    end else begin
      bit fe;
      fe = 0; val = 0;
      m_p3 = m_p2; m_p2 = m_p1; m_p1 = pwm_in;
      step = 1 << div_sel;
      per  = 1 << (W - int'(div_sel));
      e_ovr = 0; e_lerr = 0;
      if (!enable) begin
        m_mode = 0; m_n = 0; m_hi = 0; m_good = 0; e_locked = 0;
      end else if (m_mode != 0 && int'(div_sel) != m_prev_div) begin
        m_mode = 1; m_n = 0; m_hi = 0; m_good = 0; e_locked = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (rise) begin m_mode = 2; m_n = 1; m_hi = 1; end
      end else begin
        if (rise && m_n != 0) begin
          e_lerr = 1; m_n = 1; m_hi = 1; m_good = 0; e_locked = 0;
        end else begin
          m_n++;
          m_hi += int'(ins);
          if (m_n == per) begin
            fe  = 1;
            val = m_hi * step;
            if (val > (1 << W) - 1) val = (1 << W) - 1;
            val = val >> F;
            m_n = 0; m_hi = 0;
            if (m_good < 2) m_good++;
            if (m_good == 2) e_locked = 1;
          end
        end
      end
      if (fe) begin
        if (!e_valid || smp_if.sample_ready) begin e_sample = val; e_valid = 1; end
        else e_ovr = 1;
      end else if (e_valid && smp_if.sample_ready) begin
        e_valid = 0;
      end
      m_prev_div = int'(div_sel);
    end
  endtask

  task automatic tick();
    if (force_lvl >= 0) pwm_in = (force_lvl != 0);
    else pwm_in = (gen_cnt < gen_hi);
    gen_cnt = (gen_cnt + 1) % gen_per;
    case (ready_mode)
      0:       smp_if.sample_ready = 1'b1;
      1:       smp_if.sample_ready = 1'b0;
      default: smp_if.sample_ready = 1'($urandom_range(0, 1));
    endcase
    if (!rst && smp_if.sample_valid === 1'b1 && smp_if.sample_ready) begin
      last_acc = int'(smp_if.sample);
      n_acc++;
    end
    model_step();
    @(negedge clk);
    check_val("sample", 32'(smp_if.sample), 32'(e_sample));
    check_val("sample_valid", 32'(smp_if.sample_valid), 32'(e_valid));
    check_val("overrun", 32'(overrun), 32'(e_ovr));
    check_val("lock_err", 32'(lock_err), 32'(e_lerr));
    check_val("locked", 32'(locked), 32'(e_locked));
    if (lock_err === 1'b1) n_lerr++;
    if (overrun === 1'b1) n_ovr++;
  endtask

  task automatic wait_valid(input int bound);
    for (int k = 0; k < bound && smp_if.sample_valid !== 1'b1; k++) tick();
    check_val("wait_valid", 32'(smp_if.sample_valid), 32'd1);
  endtask

  initial begin
    smp_if.sample_ready = 1'b1;
    repeat (3) tick();
    check_val("rst_valid", 32'(smp_if.sample_valid), 32'd0);
    check_val("rst_locked", 32'(locked), 32'd0);
    $display("reset done");

    // 1: 128 high / 384 low at 512-clk period
    rst = 0; enable = 1; gen_cnt = 0; n_lerr = 0;
    repeat (4 * 512 + 20) tick();
    check_val("s1_sample", 32'(last_acc), 32'h40);
    check_val("s1_locked", 32'(locked), 32'd1);
    check_val("s1_lock_err_cnt", 32'(n_lerr), 32'd0);
    $display("s1 samples=%0d last=%0h", n_acc, last_acc);

    // 2: constant high, then constant low, then relock to generator
    force_lvl = 1;
    repeat (3 * 512) tick();
    check_val("s2_high", 32'(last_acc), 32'hFF);
    force_lvl = 0;
    repeat (3 * 512) tick();
    check_val("s2_low", 32'(last_acc), 32'h00);
    force_lvl = -1;
    repeat (4 * 512) tick();
    $display("s2 done last=%0h", last_acc);

    // 3: consumer stalls across three frame ends
    wait_valid(600);
    tick();
    ready_mode = 1; n_ovr = 0;
    repeat (1792) tick();
    check_val("s3_overruns", 32'(n_ovr), 32'd2);
    check_val("s3_held", 32'(smp_if.sample), 32'h40);
    ready_mode = 0; last_acc = 'hAA;
    tick();
    check_val("s3_first", 32'(last_acc), 32'h40);
    $display("s3 overruns=%0d", n_ovr);

    // 4: stray edge ~200 clk into a frame
    wait_valid(600);
    repeat (200) tick();
    n_lerr = 0; force_lvl = 1;
    repeat (10) tick();
    force_lvl = -1;
    check_val("s4_unlocked", 32'(locked), 32'd0);
    repeat (4 * 512) tick();
    check_val("s4_lock_err_cnt", 32'(n_lerr), 32'd2);
    check_val("s4_relocked", 32'(locked), 32'd1);
    $display("s4 lock_err=%0d", n_lerr);

    // 5: divSel 0 -> 2 mid-frame, 32 high of 128
    wait_valid(600);
    repeat (300) tick();
    div_sel = 2; gen_per = 128; gen_hi = 32; gen_cnt = 0; n_lerr = 0; last_acc = 'hAA;
    repeat (6 * 128) tick();
    check_val("s5_sample", 32'(last_acc), 32'h40);
    check_val("s5_lock_err_cnt", 32'(n_lerr), 32'd0);
    check_val("s5_locked", 32'(locked), 32'd1);
    $display("s5 last=%0h", last_acc);

    // 6: reset mid-frame while a sample is pending
    ready_mode = 1;
    wait_valid(300);
    repeat (50) tick();
    rst = 1;
    tick();
    check_val("s6_valid", 32'(smp_if.sample_valid), 32'd0);
    check_val("s6_sample", 32'(smp_if.sample), 32'd0);
    check_val("s6_locked", 32'(locked), 32'd0);
    rst = 0; ready_mode = 0; last_acc = 'hAA;
    repeat (5 * 128) tick();
    check_val("s6_resume", 32'(last_acc), 32'h40);
    check_val("s6_relocked", 32'(locked), 32'd1);
    $display("s6 resume last=%0h", last_acc);

    // random segments: duty, divider, ready pattern, enable drops, glitches
    for (int seg = 0; seg < 40; seg++) begin
      int d, len, ga;
      bit glitch;
      d          = $urandom_range(0, 3);
      div_sel    = O'(d);
      gen_per    = 1 << (W - d);
      gen_hi     = $urandom_range(0, gen_per);
      gen_cnt    = $urandom_range(0, gen_per - 1);
      ready_mode = $urandom_range(0, 2);
      enable     = ($urandom_range(0, 7) != 0);
      len        = $urandom_range(100, 900);
      glitch     = ($urandom_range(0, 3) == 0);
      ga         = $urandom_range(0, len - 1);
      for (int i = 0; i < len; i++) begin
        force_lvl = (glitch && i >= ga && i < ga + 3) ? 1 : -1;
        tick();
      end
      force_lvl = -1;
      $display("seg %0d div=%0d hi=%0d/%0d ready_mode=%0d en=%0d accepted=%0d", seg, d, gen_hi,
               gen_per, ready_mode, enable, n_acc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
